associative_table: RTL and testbench
====================================

ASSOCIATIVE_TABLE -- requirements
Module: associative_table

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 2, key width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ctrl  input  3  opcode, sampled each rising edge.
REQ-007 SHALL have port key  input  KEY_WIDTH  lookup/store key.
REQ-008 SHALL have port data_input  input  DATA_WIDTH  data for LOAD.
REQ-009 SHALL have port data_output  output  DATA_WIDTH  registered result.
REQ-010 SHALL have port valid  output  1  registered; result of last command is meaningful.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  registered number of valid entries.
REQ-012 SHALL have port full  output  1  registered; high iff count == DEPTH.

Function
REQ-013 SHALL hold at most one valid entry per key; match is a parallel compare of all valid entries.
REQ-014 SHALL update data_output, valid, count and full one cycle after the command edge (latency 1).
REQ-015 SHALL, on NONE (0), clear valid, hold data_output, and leave the table unchanged.
REQ-016 SHALL, on SEARCH (1): on hit, output the stored data with valid=1; on miss, output 0 with valid=0.
REQ-017 SHALL, on LOAD (2), place data_input, then output data_input with valid=1:
- key hit: overwrite that entry.
- miss, not full: write the lowest-index free entry; count+1.
- miss, full: overwrite the victim entry (REQ-024); count unchanged.
REQ-018 SHALL, on INCR (3), on hit, store data+1 modulo 2^DATA_WIDTH (0xF wraps to 0x0) and output the new value with valid=1; on miss, make no change, output 0 with valid=0.
REQ-019 SHALL, on DECR (4), behave as INCR with data-1 modulo 2^DATA_WIDTH (0x0 wraps to 0xF).
REQ-020 SHALL, on DELETE (5), on hit, invalidate the entry, output its old data with valid=1 and decrement count; on miss, output 0 with valid=0.
REQ-021 SHALL, on CLEAR (6), invalidate all entries, set count=0 and reset the victim state, with valid=0 and data_output=0.
REQ-022 SHALL treat opcode 7 exactly as NONE.
REQ-023 SHALL never let count exceed DEPTH or wrap below 0.
REQ-024 SHALL, without LRU (REQ-028), select the victim with a round-robin pointer that advances only on an eviction and wraps from DEPTH-1 to 0.

Reset
REQ-025 SHALL, while rst is high, immediately and independently of clk force all entries invalid, data_output=0, valid=0, count=0, full=0, and victim state to initial.
REQ-026 SHALL discard any command in progress when rst asserts; the first command is accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL use macro ASSOCIATIVE_TABLE_LRU_EN.
REQ-028 SHALL, with the macro defined, keep a unique recency rank per entry and make the least recently used valid entry the victim.
- Touches: SEARCH hit, LOAD, INCR hit and DECR hit make the entry most recent.
- DELETE and CLEAR do not touch.
- Ranks reset to entry index order, so entry 0 is the first victim.
REQ-029 SHALL, with the macro undefined, use round-robin replacement (REQ-024) and contain no rank logic.

Structure
REQ-030 SHALL define the opcode constants (NONE..CLEAR) and the ctrl width in shared package associative_table_pkg.
REQ-031 SHALL place the parallel key compare and the hit index/first-free priority encoding in sub-module associative_table_match.

Verification
REQ-032 SHALL cover: reset, then SEARCH key=1 -> valid=0, data_output=0, count=0, full=0.
REQ-033 SHALL cover: LOAD(1,0xE), then INCR 1 -> 0xF valid=1; INCR 1 -> 0x0; DECR 1 -> 0xF; INCR key=2 (absent) -> valid=0.
REQ-034 SHALL cover, with KEY_WIDTH=3: LOAD keys 0..3 with data 1..4 -> count=4, full=1.
- Without macro: LOAD(4,9) evicts key 0, so SEARCH 0 misses.
- With macro: SEARCH 0 first, then LOAD(4,9) evicts key 1.
REQ-035 SHALL cover: DELETE key 2 in a full table -> data_output=3, valid=1, count=3, full=0; next LOAD(5,6) fills the freed slot with no eviction.
REQ-036 SHALL cover: LOAD(1,0xE), then LOAD(1,0x7) -> count stays 1 and SEARCH 1 returns 0x7; CLEAR -> count=0.
REQ-037 SHALL cover: rst asserted between clock edges during an INCR sequence -> outputs 0 before the next edge and table empty after release.

Source files
------------

// File: rtl/associative_table_pkg.sv
// Shared opcode definitions for the associative table.
// LRU replacement is selected with `define ASSOCIATIVE_TABLE_LRU_EN; default is round-robin.
package associative_table_pkg;

    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        OP_NONE   = 3'd0,
        OP_SEARCH = 3'd1,
        OP_LOAD   = 3'd2,
        OP_INCR   = 3'd3,
        OP_DECR   = 3'd4,
        OP_DELETE = 3'd5,
        OP_CLEAR  = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    // Commands that make the addressed entry most recently used.
    function automatic logic op_touches(input op_e op, input logic hit);
        return (op == OP_LOAD) ||
               (hit && ((op == OP_SEARCH) || (op == OP_INCR) || (op == OP_DECR)));
    endfunction

endpackage

// File: rtl/associative_table_match.sv
// Parallel key compare across all valid entries, plus hit-index and
// lowest-free-slot priority encoders.
module associative_table_match #(
    parameter int KEY_WIDTH = 2,
    parameter int DEPTH     = 4
) (
    input  logic [KEY_WIDTH-1:0]            i_key,
    input  logic [DEPTH-1:0][KEY_WIDTH-1:0] i_keys,
    input  logic [DEPTH-1:0]                i_valid_vec,
    output logic                            o_hit,
    output logic [$clog2(DEPTH)-1:0]        o_hit_idx,
    output logic                            o_free,
    output logic [$clog2(DEPTH)-1:0]        o_free_idx
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_match[gi] = i_valid_vec[gi] && (i_keys[gi] == i_key);
        end
    endgenerate

    assign o_hit  = |w_match;
    assign o_free = ~&i_valid_vec;

    // Descending scan so the lowest index wins; at most one entry can match.
    always_comb begin
        o_hit_idx  = '0;
        o_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit_idx = IDX_W'(i);
            end
            if (!i_valid_vec[i]) begin
                o_free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/associative_table.sv
// Small key/value CAM with SEARCH/LOAD/INCR/DECR/DELETE/CLEAR commands and
// registered results. `define ASSOCIATIVE_TABLE_LRU_EN for LRU victim choice.
module associative_table
    import associative_table_pkg::*;
#(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CTRL_W-1:0]            ctrl,
    input  logic [KEY_WIDTH-1:0]         key,
    input  logic [DATA_WIDTH-1:0]        data_input,
    output logic [DATA_WIDTH-1:0]        data_output,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                 r_valid_vec;
    logic [DEPTH-1:0][KEY_WIDTH-1:0]  r_keys;
    logic [DATA_WIDTH-1:0]            r_data [DEPTH];
    logic [DATA_WIDTH-1:0]            r_dout;
    logic                             r_val;
    logic [CNT_W-1:0]                 r_count;
    logic                             r_full;

    op_e                              w_op;
    logic                             w_hit;
    logic [IDX_W-1:0]                 w_hit_idx;
    logic                             w_free;
    logic [IDX_W-1:0]                 w_free_idx;
    logic [IDX_W-1:0]                 w_victim;
    logic [DATA_WIDTH-1:0]            w_stored;
    logic                             w_wr_en;
    logic [IDX_W-1:0]                 w_wr_idx;
    logic [DATA_WIDTH-1:0]            w_wr_data;
    logic                             w_set_valid;
    logic                             w_del;
    logic                             w_clear;
    logic [DATA_WIDTH-1:0]            w_dout_next;
    logic                             w_val_next;
    logic [CNT_W-1:0]                 w_cnt_next;

    assign w_op = op_e'(ctrl);

    associative_table_match #(
        .KEY_WIDTH (KEY_WIDTH),
        .DEPTH     (DEPTH)
    ) u_match (
        .i_key       (key),
        .i_keys      (r_keys),
        .i_valid_vec (r_valid_vec),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_free      (w_free),
        .o_free_idx  (w_free_idx)
    );

    assign w_stored = r_data[w_hit_idx];

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = w_hit_idx;
        w_wr_data   = data_input;
        w_set_valid = 1'b0;
        w_del       = 1'b0;
        w_clear     = 1'b0;
        w_dout_next = r_dout;
        w_val_next  = 1'b0;
        w_cnt_next  = r_count;
        case (w_op)
            OP_SEARCH: begin
                w_dout_next = w_hit ? w_stored : '0;
                w_val_next  = w_hit;
            end
            OP_LOAD: begin
                w_wr_en     = 1'b1;
                w_set_valid = 1'b1;
                w_dout_next = data_input;
                w_val_next  = 1'b1;
                if (w_hit) begin
                    w_wr_idx = w_hit_idx;
                end else if (w_free) begin
                    w_wr_idx   = w_free_idx;
                    w_cnt_next = r_count + CNT_W'(1);
                end else begin
                    w_wr_idx = w_victim;
                end
            end
            OP_INCR, OP_DECR: begin
                w_wr_data   = (w_op == OP_INCR) ? (w_stored + DATA_WIDTH'(1))
                                                : (w_stored - DATA_WIDTH'(1));
                w_wr_en     = w_hit;
                w_dout_next = w_hit ? w_wr_data : '0;
                w_val_next  = w_hit;
            end
            OP_DELETE: begin
                w_del       = w_hit;
                w_dout_next = w_hit ? w_stored : '0;
                w_val_next  = w_hit;
                if (w_hit) begin
                    w_cnt_next = r_count - CNT_W'(1);
                end
            end
            OP_CLEAR: begin
                w_clear     = 1'b1;
                w_dout_next = '0;
                w_cnt_next  = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_vec <= '0;
            r_dout      <= '0;
            r_val       <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else begin
            if (w_clear) begin
                r_valid_vec <= '0;
            end else if (w_del) begin
                r_valid_vec[w_hit_idx] <= 1'b0;
            end else if (w_set_valid) begin
                r_valid_vec[w_wr_idx] <= 1'b1;
            end
            r_dout  <= w_dout_next;
            r_val   <= w_val_next;
            r_count <= w_cnt_next;
            r_full  <= (w_cnt_next == CNT_W'(DEPTH));
        end
    end

    // Key/data storage needs no reset: entries are qualified by r_valid_vec.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_keys[w_wr_idx] <= key;
            r_data[w_wr_idx] <= w_wr_data;
        end
    end

`ifdef ASSOCIATIVE_TABLE_LRU_EN
    // Rank 0 is least recent, DEPTH-1 most recent; ranks stay a permutation.
    logic [IDX_W-1:0] r_rank [DEPTH];
    logic             w_touch;
    logic [IDX_W-1:0] w_touch_rank;

    assign w_touch      = op_touches(w_op, w_hit);
    assign w_touch_rank = r_rank[w_wr_idx];

    always_comb begin
        w_victim = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rank[i] == '0) begin
                w_victim = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rank[i] <= IDX_W'(i);
            end
        end else if (w_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rank[i] <= IDX_W'(i);
            end
        end else if (w_touch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_idx == IDX_W'(i)) begin
                    r_rank[i] <= IDX_W'(DEPTH - 1);
                end else if (r_rank[i] > w_touch_rank) begin
                    r_rank[i] <= r_rank[i] - IDX_W'(1);
                end
            end
        end
    end
`else
    logic [IDX_W-1:0] r_rr_ptr;
    logic             w_evict;

    assign w_evict  = (w_op == OP_LOAD) && !w_hit && !w_free;
    assign w_victim = r_rr_ptr;

    // DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_clear) begin
            r_rr_ptr <= '0;
        end else if (w_evict) begin
            r_rr_ptr <= r_rr_ptr + IDX_W'(1);
        end
    end
`endif

    assign data_output = r_dout;
    assign valid       = r_val;
    assign count       = r_count;
    assign full        = r_full;

endmodule

// File: tb/tb_associative_table.sv
// Self-checking bench: directed vector table, hand sequences for eviction and
// asynchronous reset, then random commands against a behavioural model.
module tb_associative_table;

    localparam int KW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MASK  = (1 << DW) - 1;

    localparam int C_NONE = 0, C_SEARCH = 1, C_LOAD = 2, C_INCR = 3;
    localparam int C_DECR = 4, C_DELETE = 5, C_CLEAR = 6, C_RSVD = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    ctrl = '0;
    logic [KW-1:0] key = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          valid;
    logic [CW-1:0] count;
    logic          full;

    int n_checks = 0;
    int n_pass   = 0;

    associative_table #(
        .KEY_WIDTH  (KW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .key         (key),
        .data_input  (din),
        .data_output (dout),
        .valid       (valid),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays, a recency queue (oldest first) and a rotating victim counter.
    bit m_v [DEPTH];
    int m_k [DEPTH];
    int m_d [DEPTH];
    int m_cnt;
    int m_rr;
    int m_q [$];
    int m_dout;
    int m_val;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0;
            m_k[i] = 0;
            m_d[i] = 0;
        end
        m_cnt  = 0;
        m_rr   = 0;
        m_dout = 0;
        m_val  = 0;
        m_q    = {};
        for (int i = 0; i < DEPTH; i++) m_q.push_back(i);
    endfunction

    function automatic void model_touch(input int e);
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i] == e) begin
                m_q.delete(i);
                break;
            end
        end
        m_q.push_back(e);
    endfunction

    function automatic void model_step(input int op, input int k, input int d);
        int h = -1;
        int idx = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_k[i] == k) h = i;
        case (op)
            C_SEARCH: begin
                if (h >= 0) begin m_dout = m_d[h]; m_val = 1; model_touch(h); end
                else begin m_dout = 0; m_val = 0; end
            end
            C_LOAD: begin
                if (h >= 0) begin
                    idx = h;
                end else if (m_cnt < DEPTH) begin
                    for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) idx = i;
                    m_cnt++;
                end else begin
`ifdef ASSOCIATIVE_TABLE_LRU_EN
                    idx = m_q[0];
`else
                    idx  = m_rr;
                    m_rr = (m_rr + 1) % DEPTH;
`endif
                end
                m_v[idx] = 1'b1; m_k[idx] = k; m_d[idx] = d;
                m_dout = d; m_val = 1;
                model_touch(idx);
            end
            C_INCR, C_DECR: begin
                if (h >= 0) begin
                    m_d[h] = (m_d[h] + ((op == C_INCR) ? 1 : -1)) & MASK;
                    m_dout = m_d[h]; m_val = 1;
                    model_touch(h);
                end else begin
                    m_dout = 0; m_val = 0;
                end
            end
            C_DELETE: begin
                if (h >= 0) begin
                    m_dout = m_d[h]; m_val = 1; m_v[h] = 1'b0; m_cnt--;
                end else begin
                    m_dout = 0; m_val = 0;
                end
            end
            C_CLEAR: model_reset();
            default: m_val = 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_out(input string tag, input int ed, input int ev, input int ec, input int ef);
        check({tag, " data_output"}, int'(dout), ed);
        check({tag, " valid"}, int'(valid), ev);
        check({tag, " count"}, int'(count), ec);
        check({tag, " full"}, int'(full), ef);
    endtask

    task automatic cmd(input int op, input int k, input int d);
        @(negedge clk);
        ctrl = op[2:0];
        key  = k[KW-1:0];
        din  = d[DW-1:0];
        @(posedge clk);
        #1;
        model_step(op, k, d);
        $display("cmd op=%0d key=%0d din=%0d -> dout=%0d valid=%0d count=%0d full=%0d",
                 op, k, d, dout, valid, count, full);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ctrl = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int op; int k; int d;
        int e_dout; int e_val; int e_cnt; int e_full;
    } vec_t;

    vec_t vecs [$];

    initial begin
        model_reset();
        vecs.push_back('{C_SEARCH, 1, 0,  0, 0, 0, 0});
        vecs.push_back('{C_LOAD,   1, 14, 14, 1, 1, 0});
        vecs.push_back('{C_INCR,   1, 0,  15, 1, 1, 0});
        vecs.push_back('{C_INCR,   1, 0,  0, 1, 1, 0});
        vecs.push_back('{C_DECR,   1, 0,  15, 1, 1, 0});
        vecs.push_back('{C_NONE,   0, 0,  15, 0, 1, 0});
        vecs.push_back('{C_INCR,   2, 0,  0, 0, 1, 0});
        vecs.push_back('{C_LOAD,   1, 7,  7, 1, 1, 0});
        vecs.push_back('{C_SEARCH, 1, 0,  7, 1, 1, 0});
        vecs.push_back('{C_CLEAR,  0, 0,  0, 0, 0, 0});
        vecs.push_back('{C_LOAD,   0, 1,  1, 1, 1, 0});
        vecs.push_back('{C_LOAD,   1, 2,  2, 1, 2, 0});
        vecs.push_back('{C_LOAD,   2, 3,  3, 1, 3, 0});
        vecs.push_back('{C_LOAD,   3, 4,  4, 1, 4, 1});
        vecs.push_back('{C_DELETE, 2, 0,  3, 1, 3, 0});
        vecs.push_back('{C_LOAD,   5, 6,  6, 1, 4, 1});
        vecs.push_back('{C_SEARCH, 0, 0,  1, 1, 4, 1});
        vecs.push_back('{C_SEARCH, 2, 0,  0, 0, 4, 1});
        vecs.push_back('{C_RSVD,   0, 0,  0, 0, 4, 1});
        vecs.push_back('{C_DELETE, 6, 0,  0, 0, 4, 1});
        vecs.push_back('{C_SEARCH, 5, 0,  6, 1, 4, 1});
        vecs.push_back('{C_CLEAR,  0, 0,  0, 0, 0, 0});
        vecs.push_back('{C_DECR,   3, 0,  0, 0, 0, 0});

        // Reset state while rst is held.
        #2;
        check_out("reset", 0, 0, 0, 0);
        do_reset();

        foreach (vecs[i]) begin
            cmd(vecs[i].op, vecs[i].k, vecs[i].d);
            check_out($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_val,
                      vecs[i].e_cnt, vecs[i].e_full);
        end

        // Eviction on a full table.
        for (int i = 0; i < 4; i++) cmd(C_LOAD, i, i + 1);
        check_out("fill", 4, 1, 4, 1);
`ifdef ASSOCIATIVE_TABLE_LRU_EN
        cmd(C_SEARCH, 0, 0);
        check_out("lru touch0", 1, 1, 4, 1);
        cmd(C_LOAD, 4, 9);
        check_out("lru load4", 9, 1, 4, 1);
        cmd(C_SEARCH, 1, 0);
        check_out("lru key1 gone", 0, 0, 4, 1);
        cmd(C_SEARCH, 0, 0);
        check_out("lru key0 kept", 1, 1, 4, 1);
`else
        cmd(C_LOAD, 4, 9);
        check_out("rr load4", 9, 1, 4, 1);
        cmd(C_SEARCH, 0, 0);
        check_out("rr key0 gone", 0, 0, 4, 1);
        cmd(C_LOAD, 5, 10);
        check_out("rr load5", 10, 1, 4, 1);
        cmd(C_SEARCH, 1, 0);
        check_out("rr key1 gone", 0, 0, 4, 1);
        cmd(C_SEARCH, 2, 0);
        check_out("rr key2 kept", 3, 1, 4, 1);
`endif

        // Asynchronous reset between edges during an INCR sequence.
        cmd(C_CLEAR, 0, 0);
        cmd(C_LOAD, 1, 13);
        cmd(C_INCR, 1, 0);
        check_out("pre-rst incr", 14, 1, 1, 0);
        @(negedge clk);
        ctrl = 3'(C_INCR);
        key  = 3'd1;
        #2;
        rst = 1'b1;
        #1;
        check_out("async rst", 0, 0, 0, 0);
        @(negedge clk);
        ctrl = '0;
        rst  = 1'b0;
        model_reset();
        cmd(C_SEARCH, 1, 0);
        check_out("post-rst search", 0, 0, 0, 0);

        // Random commands against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int op;
            int k;
            int d;
            op = $urandom_range(0, 7);
            if (op == C_CLEAR && $urandom_range(0, 9) != 0) op = C_LOAD;
            k = $urandom_range(0, 5);
            d = $urandom_range(0, MASK);
            cmd(op, k, d);
            check_out($sformatf("rnd%0d op%0d", n, op), m_dout, m_val, m_cnt,
                      (m_cnt == DEPTH) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
